add_arbiter: RTL and testbench

ADD_ARBITER -- requirements
Module: add_arbiter

---
 rtl/add_arbiter_pkg.sv | 18 +
 rtl/add_arbiter_add.sv | 15 +
 rtl/add_arbiter.sv | 101 ++++++++++
 tb/tb_add_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/add_arbiter_pkg.sv
// Shared definitions for the add_arbiter slice: output-buffer state encoding,
// default sizing and a small index helper.
package add_arbiter_pkg;

  localparam int DEFAULT_BIT_WIDTH = 14;
  localparam int DEFAULT_N_REQ     = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_e;

  // Round-robin successor of a requester index.
  function automatic int wrapInc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/add_arbiter_add.sv
// Combinational adder shared by all requesters; the carry out is discarded so
// the sum wraps modulo 2^BIT_WIDTH.
module add
  import add_arbiter_pkg::*;
#(
  parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH
) (
  input  logic [BIT_WIDTH-1:0] a_i,
  input  logic [BIT_WIDTH-1:0] b_i,
  output logic [BIT_WIDTH-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/add_arbiter.sv
// Round-robin arbiter time-sharing one adder among N_REQ valid/ready requesters,
// with a one-entry output buffer that can drain and refill in the same cycle.
module add_arbiter
  import add_arbiter_pkg::*;
#(
  parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH,
  parameter int N_REQ     = DEFAULT_N_REQ,
  localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*BIT_WIDTH-1:0] req_a,
  input  logic [N_REQ*BIT_WIDTH-1:0] req_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BIT_WIDTH-1:0]       out_sum,
  output logic [ID_W-1:0]            out_id
);

  buf_state_e           state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [BIT_WIDTH-1:0] sum_q, sum_d;

  logic                 slotFree;
  logic                 found;
  logic                 accept;
  logic [ID_W-1:0]      grantIdx;
  logic [ID_W-1:0]      idx;
  int                   idxInt;
  logic [BIT_WIDTH-1:0] aSel, bSel, addSum;

  // Rotating priority search starting at ptr_q; gated by rst_n so nothing is
  // granted while the block is held in reset.
  always_comb begin
    slotFree  = rst_n && ((state_q == EMPTY) || out_ready);
    found     = 1'b0;
    grantIdx  = '0;
    idx       = '0;
    idxInt    = 0;
    req_ready = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idxInt = int'(ptr_q) + k;
      if (idxInt >= N_REQ) idxInt = idxInt - N_REQ;
      idx = ID_W'(idxInt);
      if (!found && req_valid[idx]) begin
        found    = 1'b1;
        grantIdx = idx;
      end
    end
    accept = slotFree && found;
    if (accept) req_ready[grantIdx] = 1'b1;
  end

  assign aSel = req_a[int'(grantIdx)*BIT_WIDTH +: BIT_WIDTH];
  assign bSel = req_b[int'(grantIdx)*BIT_WIDTH +: BIT_WIDTH];

  add #(
    .BIT_WIDTH(BIT_WIDTH)
  ) uAdd (
    .a_i  (aSel),
    .b_i  (bSel),
    .sum_o(addSum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      id_q    <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
    end
  end

  // An accept always (re)fills the buffer, even when it is draining this cycle.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = FULL;
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
    sum_d = accept ? addSum : sum_q;
    id_d  = accept ? grantIdx : id_q;
    ptr_d = accept ? ID_W'(wrapInc(int'(grantIdx), N_REQ)) : ptr_q;
  end

  always_comb begin
    out_valid = (state_q == FULL);
    out_sum   = sum_q;
    out_id    = id_q;
  end

endmodule

// File: tb/tb_add_arbiter.sv
// Self-checking bench for add_arbiter: directed vector table, hand-written
// backpressure/reset sequences, then randomized traffic against a reference model.
module tb_add_arbiter;

  localparam int BW = 14;
  localparam int NR = 4;
  localparam int AW = NR * BW;

  logic          clk;
  logic          rst_n;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_ready;
  logic [AW-1:0] req_a;
  logic [AW-1:0] req_b;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_sum;
  logic [1:0]    out_id;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]    valid;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic          outReady;
    logic [3:0]    expReady;
    logic          expValid;
    logic [BW-1:0] expSum;
    logic [1:0]    expId;
  } vec_t;

  vec_t vecs[10];

  // Reference model state for the randomized phase
  bit          fullM;
  int          sumM;
  int          idM;
  int          ptrM;
  int          aArr[NR];
  int          bArr[NR];
  logic [3:0]  rndValid;
  logic [AW-1:0] rndA, rndB;
  logic        rndReady;
  logic [3:0]  expReady;
  int          g;

  add_arbiter #(
    .BIT_WIDTH(BW),
    .N_REQ    (NR)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_id   (out_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [AW-1:0] pk(input int x0, input int x1, input int x2, input int x3);
    return {BW'(x3), BW'(x2), BW'(x1), BW'(x0)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [AW-1:0] a,
                               input logic [AW-1:0] b, input logic ordy);
    req_valid = v;
    req_a     = a;
    req_b     = b;
    out_ready = ordy;
  endtask

  initial begin
    vecs[0] = '{4'b0100, pk(0, 0, 100, 0), pk(0, 0, 23, 0), 1'b1, 4'b0100, 1'b1, 14'd123, 2'd2};
    vecs[1] = '{4'b0001, pk(16383, 0, 0, 0), pk(2, 0, 0, 0), 1'b1, 4'b0001, 1'b1, 14'd1, 2'd0};
    vecs[2] = '{4'b1111, pk(0, 10, 20, 30), pk(1, 1, 1, 1), 1'b1, 4'b0010, 1'b1, 14'd11, 2'd1};
    vecs[3] = '{4'b1111, pk(0, 10, 20, 30), pk(1, 1, 1, 1), 1'b1, 4'b0100, 1'b1, 14'd21, 2'd2};
    vecs[4] = '{4'b1111, pk(0, 10, 20, 30), pk(1, 1, 1, 1), 1'b1, 4'b1000, 1'b1, 14'd31, 2'd3};
    vecs[5] = '{4'b1111, pk(0, 10, 20, 30), pk(1, 1, 1, 1), 1'b1, 4'b0001, 1'b1, 14'd1, 2'd0};
    vecs[6] = '{4'b0000, pk(0, 0, 0, 0), pk(0, 0, 0, 0), 1'b1, 4'b0000, 1'b0, 14'd0, 2'd0};
    vecs[7] = '{4'b0010, pk(3, 7, 0, 0), pk(4, 8, 0, 0), 1'b1, 4'b0010, 1'b1, 14'd15, 2'd1};
    vecs[8] = '{4'b0001, pk(3, 7, 0, 0), pk(4, 8, 0, 0), 1'b1, 4'b0001, 1'b1, 14'd7, 2'd0};
    vecs[9] = '{4'b0011, pk(3, 7, 0, 0), pk(4, 8, 0, 0), 1'b1, 4'b0010, 1'b1, 14'd15, 2'd1};

    // Reset: requests present but nothing may be granted
    rst_n = 1'b0;
    applyStimulus(4'b1111, pk(1, 2, 3, 4), pk(1, 1, 1, 1), 1'b1);
    #3;
    checkOutput("reset_valid", out_valid, 0);
    checkOutput("reset_sum", out_sum, 0);
    checkOutput("reset_id", out_id, 0);
    checkOutput("reset_ready", req_ready, 0);
    @(negedge clk);
    applyStimulus(4'b0000, '0, '0, 1'b1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("idle_valid", out_valid, 0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].a, vecs[i].b, vecs[i].outReady);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_ready", i), req_ready, vecs[i].expReady);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_valid", i), out_valid, vecs[i].expValid);
      if (vecs[i].expValid) begin
        checkOutput($sformatf("vec%0d_sum", i), out_sum, vecs[i].expSum);
        checkOutput($sformatf("vec%0d_id", i), out_id, vecs[i].expId);
      end
    end

    // Backpressure: load 30+20 from requester 2, then stall three cycles
    applyStimulus(4'b0100, pk(0, 0, 30, 0), pk(0, 0, 20, 0), 1'b1);
    @(negedge clk);
    checkOutput("bp_load_ready", req_ready, 4'b0100);
    @(posedge clk);
    #1;
    checkOutput("bp_load_sum", out_sum, 50);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'b1111, pk(1, 2, 3, 4), pk(1, 1, 1, 1), 1'b0);
      @(negedge clk);
      checkOutput($sformatf("bp_stall%0d_ready", c), req_ready, 0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp_stall%0d_valid", c), out_valid, 1);
      checkOutput($sformatf("bp_stall%0d_sum", c), out_sum, 50);
      checkOutput($sformatf("bp_stall%0d_id", c), out_id, 2);
    end
    applyStimulus(4'b1111, pk(1, 2, 3, 4), pk(1, 1, 1, 1), 1'b1);
    @(negedge clk);
    checkOutput("bp_release_ready", req_ready, 4'b1000);
    @(posedge clk);
    #1;
    checkOutput("bp_release_id", out_id, 3);
    checkOutput("bp_release_sum", out_sum, 5);
    checkOutput("bp_release_valid", out_valid, 1);

    // Reset while FULL, then the lowest valid index wins
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", out_valid, 0);
    checkOutput("midrst_sum", out_sum, 0);
    checkOutput("midrst_id", out_id, 0);
    checkOutput("midrst_ready", req_ready, 0);
    @(negedge clk);
    applyStimulus(4'b1010, pk(0, 5, 0, 9), pk(0, 6, 0, 9), 1'b1);
    rst_n = 1'b1;
    #1;
    checkOutput("postrst_ready", req_ready, 4'b0010);
    @(posedge clk);
    #1;
    checkOutput("postrst_id", out_id, 1);
    checkOutput("postrst_sum", out_sum, 11);
    checkOutput("postrst_valid", out_valid, 1);

    // Randomized traffic against the reference model
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    fullM = 1'b0;
    sumM  = 0;
    idM   = 0;
    ptrM  = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rndValid = 4'($urandom_range(0, 15));
      rndReady = ($urandom_range(0, 3) != 0);
      for (int j = 0; j < NR; j++) begin
        aArr[j] = $urandom_range(0, 16383);
        bArr[j] = $urandom_range(0, 16383);
        rndA[j*BW +: BW] = BW'(aArr[j]);
        rndB[j*BW +: BW] = BW'(bArr[j]);
      end
      g = -1;
      expReady = '0;
      if (!fullM || rndReady) begin
        for (int k = 0; k < NR; k++) begin
          if (g < 0 && rndValid[(ptrM + k) % NR]) g = (ptrM + k) % NR;
        end
      end
      if (g >= 0) expReady[g] = 1'b1;
      applyStimulus(rndValid, rndA, rndB, rndReady);
      @(negedge clk);
      checkOutput("rnd_ready", req_ready, expReady);
      @(posedge clk);
      #1;
      if (g >= 0) begin
        fullM = 1'b1;
        sumM  = (aArr[g] + bArr[g]) % 16384;
        idM   = g;
        ptrM  = (g + 1) % NR;
      end else if (fullM && rndReady) begin
        fullM = 1'b0;
      end
      checkOutput("rnd_valid", out_valid, fullM);
      if (fullM) begin
        checkOutput("rnd_sum", out_sum, sumM);
        checkOutput("rnd_id", out_id, idM);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
